// File: rtl/ritc_vdd_dac_pkg.sv
// Shared definitions for the RITC VDD DAC loader: widths, sequencer states and frame layout.
package ritc_vdd_dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;

  typedef enum logic [1:0] {IDLE, FRAME, GAP, CHECK} state_e;

  // Frame layout, MSB first on the wire: {cmd[2:0], channel, code[11:0]}.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0]        cmd,
                                                     input logic              ch,
                                                     input logic [DATA_W-1:0] code);
    return {cmd, ch, code};
  endfunction

endpackage

// File: rtl/ritc_spi_frame_tx.sv
// Single 16-bit SPI frame serializer: CS_n low for 33*CLK_DIV cycles, data MSB first,
// launched on falling SCLK and sampled by the DAC on rising SCLK.
module ritc_spi_frame_tx import ritc_vdd_dac_pkg::*; #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               cs_n,
  output logic               sclk,
  output logic               din,
  output logic               frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]         div_q;
  logic [4:0]         bit_q;
  logic [FRAME_W-1:0] sh_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               div_last;

  assign div_last = (div_q == DIV_LAST);
  // High during the last cycle of the trailing low phase; CS_n rises at the next edge.
  assign frame_done = ~cs_n_q & ~sclk_q & div_last & (bit_q == 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else if (cs_n_q) begin
      if (start) begin
        cs_n_q <= 1'b0;
        sclk_q <= 1'b0;
        div_q  <= '0;
        bit_q  <= '0;
        sh_q   <= word;
      end
    end else if (div_last) begin
      div_q <= '0;
      if (sclk_q) begin
        sclk_q <= 1'b0;
        sh_q   <= sh_q << 1;
        bit_q  <= bit_q + 5'd1;
      end else if (bit_q == 5'd16) begin
        cs_n_q <= 1'b1;
        sh_q   <= '0;
      end else begin
        sclk_q <= 1'b1;
      end
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign din  = sh_q[FRAME_W-1] & ~cs_n_q;

endmodule

// File: rtl/ritc_vdd_dac_loader.sv
// Stages the two RITC VDD servo codes and, on each update rising edge, loads them into the
// dual-channel DAC as two SPI frames (R0 then R1), folding mid-sequence updates into one rerun.
module ritc_vdd_dac_loader import ritc_vdd_dac_pkg::*; #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [2:0]  DAC_CMD = 3'b001
) (
  input  logic              user_clk_i,
  input  logic              user_rst_n_i,
  input  logic              servo_addr_i,
  input  logic              servo_wr_i,
  input  logic              servo_update_i,
  input  logic [DATA_W-1:0] servo_i,
  output logic              dac_cs_n_o,
  output logic              dac_sclk_o,
  output logic              dac_din_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] vdd_r0_o,
  output logic [DATA_W-1:0] vdd_r1_o
);

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_e            state_q, state_d;
  logic              ch_q, ch_d;
  logic [7:0]        gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              upd_q;
  logic [DATA_W-1:0] stage0_q, stage1_q;
  logic [DATA_W-1:0] act0_q, act0_d, act1_q, act1_d;
  logic              upd_edge;
  logic              tx_start, tx_ch, tx_done, tx_cs_n;
  logic [FRAME_W-1:0] tx_word;

  assign upd_edge = servo_update_i & ~upd_q;

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      stage0_q <= '0;
      stage1_q <= '0;
    end else if (servo_wr_i) begin
      if (servo_addr_i) stage1_q <= servo_i;
      else              stage0_q <= servo_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    gap_d    = gap_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    act0_d   = act0_q;
    act1_d   = act1_q;
    tx_start = 1'b0;
    tx_ch    = ch_q;
    if (upd_edge && state_q != IDLE) pend_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (upd_edge) begin
          act0_d  = stage0_q;
          act1_d  = stage1_q;
          busy_d  = 1'b1;
          ch_d    = 1'b0;
          state_d = FRAME;
        end
      end
      FRAME: begin
        tx_start = tx_cs_n;
        if (tx_done) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          if (!ch_q) begin
            // Launch R1 in the last gap cycle so CS_n stays high exactly CS_GAP cycles.
            tx_start = 1'b1;
            tx_ch    = 1'b1;
            ch_d     = 1'b1;
            state_d  = FRAME;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (pend_q || upd_edge) begin
          pend_d  = 1'b0;
          act0_d  = stage0_q;
          act1_d  = stage1_q;
          ch_d    = 1'b0;
          state_d = FRAME;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q <= IDLE;
      ch_q    <= 1'b0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      upd_q   <= 1'b0;
      act0_q  <= '0;
      act1_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      upd_q   <= servo_update_i;
      act0_q  <= act0_d;
      act1_q  <= act1_d;
    end
  end

  assign tx_word = build_frame(DAC_CMD, tx_ch, tx_ch ? act1_q : act0_q);

  ritc_spi_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk        (user_clk_i),
    .rst_n      (user_rst_n_i),
    .start      (tx_start),
    .word       (tx_word),
    .cs_n       (tx_cs_n),
    .sclk       (dac_sclk_o),
    .din        (dac_din_o),
    .frame_done (tx_done)
  );

  assign dac_cs_n_o = tx_cs_n;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign vdd_r0_o   = act0_q;
  assign vdd_r1_o   = act1_q;

endmodule

// File: tb/tb_ritc_vdd_dac_loader.sv
// Directed bench for ritc_vdd_dac_loader: frames are captured on SCLK rising edges and
// compared with hand-computed words and cycle counts.
module tb_ritc_vdd_dac_loader;

  logic        user_clk_i = 1'b0;
  logic        user_rst_n_i = 1'b0;
  logic        servo_addr_i = 1'b0;
  logic        servo_wr_i = 1'b0;
  logic        servo_update_i = 1'b0;
  logic [11:0] servo_i = '0;
  logic        dac_cs_n_o, dac_sclk_o, dac_din_o, busy_o, done_o;
  logic [11:0] vdd_r0_o, vdd_r1_o;

  int tests = 0;
  int fails = 0;
  int nsclk = 0;
  int ndone = 0;
  logic [15:0] cap = '0;
  int          nbits = 0;
  logic [15:0] frames[$];
  int          fbits[$];

  always #5 user_clk_i = ~user_clk_i;

  ritc_vdd_dac_loader dut (
    .user_clk_i     (user_clk_i),
    .user_rst_n_i   (user_rst_n_i),
    .servo_addr_i   (servo_addr_i),
    .servo_wr_i     (servo_wr_i),
    .servo_update_i (servo_update_i),
    .servo_i        (servo_i),
    .dac_cs_n_o     (dac_cs_n_o),
    .dac_sclk_o     (dac_sclk_o),
    .dac_din_o      (dac_din_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .vdd_r0_o       (vdd_r0_o),
    .vdd_r1_o       (vdd_r1_o)
  );

  // A CS_n rise closes a frame (full or aborted); SCLK rises while selected shift one bit in.
  always @(posedge dac_sclk_o or posedge dac_cs_n_o) begin
    if (dac_cs_n_o) begin
      frames.push_back(cap);
      fbits.push_back(nbits);
      cap = '0;
      nbits = 0;
    end else begin
      cap = {cap[14:0], dac_din_o};
      nbits++;
    end
  end

  always @(posedge dac_sclk_o) nsclk++;
  always @(negedge user_clk_i) if (done_o) ndone++;

  task automatic tick();
    @(posedge user_clk_i);
    #1;
  endtask

  task automatic write_servo(input logic a, input logic [11:0] v);
    servo_addr_i = a;
    servo_i = v;
    servo_wr_i = 1'b1;
    tick();
    servo_wr_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (done_o === 1'b1) begin
        t = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int s0, f0, bad;
    user_rst_n_i = 1'b0;
    repeat (3) tick();
    tests++;
    if ({dac_cs_n_o, dac_sclk_o, dac_din_o, busy_o, done_o} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 10000",
               {dac_cs_n_o, dac_sclk_o, dac_din_o, busy_o, done_o});
    end
    tests++;
    if ({vdd_r0_o, vdd_r1_o} !== 24'h0) begin
      fails++;
      $display("FAIL reset_vdd got %h want 000000", {vdd_r0_o, vdd_r1_o});
    end
    user_rst_n_i = 1'b1;
    s0 = nsclk;
    f0 = frames.size();
    bad = 0;
    repeat (1000) begin
      tick();
      if (dac_cs_n_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || dac_din_o !== 1'b0) bad++;
    end
    tests++;
    if (nsclk - s0 != 0 || frames.size() != f0) begin
      fails++;
      $display("FAIL idle_sclk got %0d edges %0d frames want 0 0", nsclk - s0, frames.size() - f0);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_outputs got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_basic();
    int b, d0, cs_t, done_t, busy_bad, din_bad;
    write_servo(1'b0, 12'hA5C);
    write_servo(1'b1, 12'h3F1);
    b = frames.size();
    d0 = ndone;
    servo_update_i = 1'b1;
    tick();
    tests++;
    if ({busy_o, dac_cs_n_o, vdd_r0_o, vdd_r1_o} !== {2'b11, 24'hA5C3F1}) begin
      fails++;
      $display("FAIL basic_copy got busy=%b cs=%b r=%h want busy=1 cs=1 r=a5c3f1",
               busy_o, dac_cs_n_o, {vdd_r0_o, vdd_r1_o});
    end
    cs_t = -1; done_t = -1; busy_bad = 0; din_bad = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (cs_t < 0 && dac_cs_n_o === 1'b0) cs_t = k;
      if (done_t < 0 && done_o === 1'b1) done_t = k;
      if (done_t < 0 && busy_o !== 1'b1) busy_bad++;
      if (dac_cs_n_o === 1'b1 && dac_din_o !== 1'b0) din_bad++;
    end
    tests++;
    if (cs_t != 1) begin
      fails++;
      $display("FAIL basic_cs_latency got %0d want 1", cs_t);
    end
    tests++;
    if (done_t != 270) begin
      fails++;
      $display("FAIL basic_done_latency got %0d want 270", done_t);
    end
    tests++;
    if (ndone - d0 != 1 || busy_bad != 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_done got dones=%0d busy_gaps=%0d busy=%b want 1 0 0",
               ndone - d0, busy_bad, busy_o);
    end
    tests++;
    if (frames.size() != b + 2 || frames[b] !== 16'h2A5C || frames[b+1] !== 16'h33F1 ||
        fbits[b] != 16 || fbits[b+1] != 16) begin
      fails++;
      $display("FAIL basic_frames got n=%0d %h/%0d %h/%0d want 2 2a5c/16 33f1/16",
               frames.size() - b, frames[b], fbits[b], frames[b+1], fbits[b+1]);
    end
    tests++;
    if (din_bad != 0) begin
      fails++;
      $display("FAIL basic_din_idle got %0d cycles want 0", din_bad);
    end
    servo_update_i = 1'b0;
    tick();
  endtask

  task automatic test_write_during();
    int b, t;
    b = frames.size();
    servo_update_i = 1'b1;
    tick();
    repeat (30) tick();
    write_servo(1'b1, 12'h123);
    wait_done(400, t);
    tests++;
    if (t < 0 || frames.size() != b + 2 || frames[b] !== 16'h2A5C || frames[b+1] !== 16'h33F1) begin
      fails++;
      $display("FAIL wr_inflight got t=%0d n=%0d %h %h want done 2 2a5c 33f1",
               t, frames.size() - b, frames[b], frames[b+1]);
    end
    tests++;
    if (vdd_r1_o !== 12'h3F1) begin
      fails++;
      $display("FAIL wr_r1_hold got %h want 3f1", vdd_r1_o);
    end
    servo_update_i = 1'b0;
    tick();
    servo_update_i = 1'b1;
    tick();
    tests++;
    if (vdd_r1_o !== 12'h123) begin
      fails++;
      $display("FAIL wr_r1_next got %h want 123", vdd_r1_o);
    end
    wait_done(400, t);
    tests++;
    if (t < 0 || frames.size() != b + 4 || frames[b+2] !== 16'h2A5C || frames[b+3] !== 16'h3123) begin
      fails++;
      $display("FAIL wr_next_frames got t=%0d n=%0d %h %h want done 4 2a5c 3123",
               t, frames.size() - b, frames[b+2], frames[b+3]);
    end
    servo_update_i = 1'b0;
    tick();
  endtask

  task automatic test_multi_edge();
    int b, d0, busy_bad, done_t;
    b = frames.size();
    d0 = ndone;
    servo_update_i = 1'b1;
    tick();
    busy_bad = 0;
    done_t = -1;
    for (int k = 1; k <= 1200; k++) begin
      if (k == 20) servo_update_i = 1'b0;
      if (k == 25) servo_update_i = 1'b1;
      if (k == 30) begin
        servo_addr_i = 1'b0;
        servo_i = 12'h7E4;
        servo_wr_i = 1'b1;
      end
      if (k == 31) servo_wr_i = 1'b0;
      if (k == 40) servo_update_i = 1'b0;
      if (k == 45) servo_update_i = 1'b1;
      tick();
      if (done_t < 0 && done_o === 1'b1) done_t = k;
      if (done_t < 0 && busy_o !== 1'b1) busy_bad++;
    end
    tests++;
    if (frames.size() != b + 4 || frames[b] !== 16'h2A5C || frames[b+1] !== 16'h3123 ||
        frames[b+2] !== 16'h27E4 || frames[b+3] !== 16'h3123) begin
      fails++;
      $display("FAIL multi_frames got n=%0d %h %h %h %h want 4 2a5c 3123 27e4 3123",
               frames.size() - b, frames[b], frames[b+1], frames[b+2], frames[b+3]);
    end
    tests++;
    if (ndone - d0 != 1 || busy_bad != 0 || done_t < 0) begin
      fails++;
      $display("FAIL multi_busy_done got dones=%0d busy_gaps=%0d t=%0d want 1 0 done",
               ndone - d0, busy_bad, done_t);
    end
    tests++;
    if (vdd_r0_o !== 12'h7E4) begin
      fails++;
      $display("FAIL multi_r0 got %h want 7e4", vdd_r0_o);
    end
    servo_update_i = 1'b0;
    tick();
  endtask

  task automatic test_held();
    int b, d0, t;
    b = frames.size();
    d0 = ndone;
    servo_update_i = 1'b1;
    repeat (600) tick();
    tests++;
    if (frames.size() != b + 2 || ndone - d0 != 1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL held_once got frames=%0d dones=%0d busy=%b want 2 1 0",
               frames.size() - b, ndone - d0, busy_o);
    end
    servo_update_i = 1'b0;
    tick();
    servo_update_i = 1'b1;
    wait_done(400, t);
    tests++;
    if (t < 0 || frames.size() != b + 4 || frames[b+2] !== 16'h27E4 || frames[b+3] !== 16'h3123) begin
      fails++;
      $display("FAIL held_retrigger got t=%0d n=%0d %h %h want done 4 27e4 3123",
               t, frames.size() - b, frames[b+2], frames[b+3]);
    end
    servo_update_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int b, s, t;
    bit found;
    b = frames.size();
    s = nsclk;
    found = 0;
    servo_update_i = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (nsclk - s == 24) begin
        found = 1;
        break;
      end
    end
    repeat (6) tick();
    #2 user_rst_n_i = 1'b0;
    #1;
    tests++;
    if (!found || {dac_cs_n_o, dac_sclk_o, dac_din_o, busy_o, done_o} !== 5'b10000 ||
        {vdd_r0_o, vdd_r1_o} !== 24'h0) begin
      fails++;
      $display("FAIL rst_async got found=%0d ctl=%b r=%h want 1 10000 000000", found,
               {dac_cs_n_o, dac_sclk_o, dac_din_o, busy_o, done_o}, {vdd_r0_o, vdd_r1_o});
    end
    tests++;
    if (frames.size() != b + 2 || fbits[b+1] != 8) begin
      fails++;
      $display("FAIL rst_partial got n=%0d bits=%0d want 2 8", frames.size() - b, fbits[b+1]);
    end
    servo_update_i = 1'b0;
    repeat (3) tick();
    user_rst_n_i = 1'b1;
    tick();
    servo_update_i = 1'b1;
    wait_done(400, t);
    tests++;
    if (t < 0 || frames.size() != b + 4 || frames[b+2] !== 16'h2000 || frames[b+3] !== 16'h3000) begin
      fails++;
      $display("FAIL rst_resend got t=%0d n=%0d %h %h want done 4 2000 3000",
               t, frames.size() - b, frames[b+2], frames[b+3]);
    end
    servo_update_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_during();
    test_multi_edge();
    test_held();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ritc_vdd_dac_loader.md
# ritc_vdd_dac_loader

Downstream consumer of the RITC phase scanner's servo interface. Captures the two 12-bit RITC VDD servo values written by the scan PicoBlaze into staging registers. On a rising edge of the update strobe, it copies both values to active registers. It then serializes them as two 16-bit SPI frames (R0 first, then R1) to the external dual-channel VDD DAC.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in user_clk_i cycles; legal range 1–255.
- CS_GAP, 2: user_clk_i cycles CS_n is held high between frames; legal range 1–255.
- DAC_CMD, 3'b001: 3-bit command field prefixed to every frame.

Ports:
- user_clk_i, in, 1: sole clock.
- user_rst_n_i, in, 1: reset, asynchronous, active-low.
- servo_addr_i, in, 1: staging select; 0 = R0, 1 = R1.
- servo_wr_i, in, 1: one-cycle write strobe for servo_i into the selected staging register.
- servo_update_i, in, 1: level input; its rising edge requests a DAC load.
- servo_i, in, 12: VDD code.
- dac_cs_n_o, out, 1: DAC chip select, active-low.
- dac_sclk_o, out, 1: DAC serial clock; idles low.
- dac_din_o, out, 1: DAC serial data, MSB first.
- busy_o, out, 1: high from load start until return to IDLE.
- done_o, out, 1: one-cycle pulse on return to IDLE.
- vdd_r0_o, out, 12: active R0 code, for readback.
- vdd_r1_o, out, 12: active R1 code, for readback.

## Operation
- Reset values:
  - dac_cs_n_o = 1.
  - dac_sclk_o, dac_din_o, busy_o, done_o = 0.
  - Staging, active, pending and the update-edge register all = 0.
- Staging write: servo_wr_i=1 loads staging[servo_addr_i] <= servo_i. Writes are accepted in every state, including while busy.
- Edge detect: upd_d <= servo_update_i; edge = servo_update_i & ~upd_d.
- State machine:
  - IDLE, on edge: active <= staging (the values before any same-cycle write); busy_o <= 1; go to FRAME with ch=0.
  - FRAME: CS_n low; shift the 16-bit word {DAC_CMD, ch, active[ch]} MSB first; then go to GAP.
  - GAP: CS_n high for CS_GAP cycles. If ch=0, set ch=1 and return to FRAME. If ch=1, go to CHECK.
  - CHECK: if pending, clear pending, set active <= staging, and return to FRAME with ch=0; busy_o stays high throughout. Otherwise go to IDLE with busy_o <= 0 and done_o = 1 for one cycle.
- An edge in any state other than IDLE sets pending. Multiple edges collapse into one pending request.
- A staging write during a sequence does not alter the frame in flight; it is picked up by the next copy.
- Asynchronous reset mid-frame aborts the frame immediately: CS_n returns high and all state is lost. The DAC discards the partial frame.

## Timing
- The edge is seen one cycle after servo_update_i rises. The active registers and busy_o update at that clock edge. CS_n falls one cycle later.
- Frame phases:
  - CS_n falling edge: dac_din_o = bit15 and SCLK is low.
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - dac_din_o changes only on SCLK falling edges or at CS_n fall; the DAC samples on SCLK rising edges.
  - After the 16th high phase, SCLK is held low for CLK_DIV cycles, then CS_n rises.
- CS_n low time per frame is 33*CLK_DIV cycles (132 with defaults).
- Full two-frame sequence with defaults:
  - From CS_n first falling to done_o: 2*(132+2)+1 = 269 cycles.
  - From the update edge to done_o: 270 cycles.
- dac_din_o returns to 0 while CS_n is high.

## Structure
- Package ritc_vdd_dac_pkg holds the following shared definitions:
  - FRAME_W=16 and DATA_W=12.
  - The state enum {IDLE, FRAME, GAP, CHECK}.
  - A frame-build function.
- Sub-module ritc_spi_frame_tx is the single-frame serializer:
  - Inputs: start, 16-bit word.
  - Outputs: cs_n, sclk, din, frame_done.
  - It owns the CLK_DIV counter and the bit counter.
  - The top level owns staging, active, pending, the edge detect and the sequencing FSM.

## Test plan
- Reset then idle: outputs hold reset values and no SCLK toggles for 1000 cycles.
- Write R0=12'hA5C and R1=12'h3F1, then raise update:
  - Frames 16'h2A5C then 16'h33F1, sampled on SCLK rising edges.
  - vdd_r0_o=A5C and vdd_r1_o=3F1.
  - done_o pulses once, 270 cycles after the edge.
- Write R1=12'h123 during frame 0: the in-flight frames are unchanged, and vdd_r1_o changes only at the next update.
- Two extra update edges mid-sequence: exactly one additional two-frame sequence follows, using the latest staging; busy_o stays high throughout; exactly one done_o pulse.
- Update held high for 500 cycles: exactly one sequence runs; a second sequence needs a low-then-high transition.
- Assert reset on bit 7 of frame 1: dac_cs_n_o=1 asynchronously and all outputs return to reset values. A subsequent update resends 0x2000 and 0x3000 (staging was cleared by reset).
